// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad and publishes a whole-frame debounced key vector.
// Latency: 2-flop col sync plus DEBOUNCE_FRAMES frames of 4*SCAN_DIV cycles; no backpressure (free-running scan).
// Optional KEYPAD_GHOST_REJECT_EN: frames with 3+ keys set are dropped before debounce.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] keyboard,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    logic [3:0]    col_s1;
    logic [3:0]    col_s2;
    logic [PW-1:0] phase;
    logic [1:0]    row_idx;
    logic [15:0]   raw;
    logic [15:0]   cand;
    logic [CW-1:0] cnt;

    logic          sample_now;
    logic          frame_end;
    logic [1:0]    next_idx;
    logic [15:0]   frame_new;
    logic          same;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_next;
    logic          accept;

    always_comb begin
        sample_now = (phase == PH_LAST);
        frame_end  = sample_now && (row_idx == 2'd3);
        next_idx   = row_idx + 2'd1;
        // Row 3 is latched on the same edge the frame is evaluated, so splice it in here.
        frame_new  = {~col_s2, raw[11:0]};
        same       = (frame_new == cand);
        cnt_inc    = (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
        cnt_next   = same ? cnt_inc : '0;
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic [4:0] pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + 5'(frame_new[i]);
        end
        accept = (pop < 5'd3);
    end
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            col_s1     <= 4'b1111;
            col_s2     <= 4'b1111;
            phase      <= '0;
            row_idx    <= 2'd0;
            row        <= 4'b1110;
            raw        <= '0;
            cand       <= '0;
            cnt        <= '0;
            keyboard   <= '0;
            frame_done <= 1'b0;
        end else begin
            col_s1     <= col;
            col_s2     <= col_s1;
            frame_done <= frame_end;

            if (sample_now) begin
                raw[{row_idx, 2'b00} +: 4] <= ~col_s2;
                phase   <= '0;
                row_idx <= next_idx;
                row     <= ~(4'b0001 << next_idx);
            end else begin
                phase <= phase + PW'(1);
            end

            if (frame_end && accept) begin
                if (same) begin
                    cnt <= cnt_inc;
                end else begin
                    cand <= frame_new;
                    cnt  <= '0;
                end
                // A single-frame debounce publishes a fresh candidate immediately.
                if (cnt_next == CNT_LAST) begin
                    keyboard <= frame_new;
                end
            end
        end
    end

endmodule
